// File: rtl/d3s_phase_gen.sv
// Four-lane NCO phase accumulator for the D3S DAC path.
// Each clock produces four consecutive 14-bit phases (lane 0 earliest) for the LUT stage.

module d3s_phase_lane #(
    parameter int ACC_BITS   = 32,
    parameter int PHASE_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACC_BITS-1:0]   acc,
    input  logic [ACC_BITS-1:0]   step,
    input  logic [PHASE_BITS-1:0] ofs,
    output logic [PHASE_BITS-1:0] phase
);
    // Only the top PHASE_BITS of the lane sum are ever consumed, so only they are stored.
    logic [PHASE_BITS-1:0] sum_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_hi <= '0;
            phase  <= '0;
        end else begin
            sum_hi <= PHASE_BITS'((acc + step) >> (ACC_BITS - PHASE_BITS));
            phase  <= sum_hi + ofs;
        end
    end
endmodule

module d3s_phase_gen #(
    parameter int g_acc_bits   = 32,
    parameter int g_phase_bits = 14
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic [g_acc_bits-1:0]     ftw_i,
    input  logic                      ftw_load_i,
    output logic                      ftw_ack_o,
    input  logic                      sync_i,
    input  logic [g_phase_bits-1:0]   phase_ofs_i,
    output logic [4*g_phase_bits-1:0] phase_divided_o,
    output logic                      phase_valid_o
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                                   state, state_nxt;
    logic [g_acc_bits-1:0]                    ftw_r;
    logic [g_acc_bits-1:0]                    acc;
    logic [NUM_LANES:0][g_acc_bits-1:0]       mult;
    logic                                     sync_r;
    logic [1:0]                               vld_pipe;
    logic [1:0]                               ack_pipe;
    logic [NUM_LANES-1:0][g_phase_bits-1:0]   lane_phase;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = ARM;
            ARM:     state_nxt = RUN;
            RUN:     if (!enable_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            ftw_r    <= '0;
            mult     <= '0;
            acc      <= '0;
            sync_r   <= 1'b0;
            vld_pipe <= '0;
            ack_pipe <= '0;
        end else begin
            state <= state_nxt;
            if (ftw_load_i)
                ftw_r <= ftw_i;
            // mult[0] is the zero step of lane 0; mult[NUM_LANES] advances the accumulator.
            for (int k = 0; k <= NUM_LANES; k++)
                mult[k] <= ftw_r * g_acc_bits'(k);
            // A sync outside RUN is dropped: acc is already zero there.
            sync_r   <= sync_i && (state == RUN);
            ack_pipe <= {ack_pipe[0], ftw_load_i};
            vld_pipe <= {vld_pipe[0], state == RUN};
            if (state == RUN && !sync_r)
                acc <= acc + mult[NUM_LANES];
            else
                acc <= '0;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        d3s_phase_lane #(
            .ACC_BITS  (g_acc_bits),
            .PHASE_BITS(g_phase_bits)
        ) u_lane (
            .clk  (clk_i),
            .rst_n(rst_n_i),
            .acc  (acc),
            .step (mult[k]),
            .ofs  (phase_ofs_i),
            .phase(lane_phase[k])
        );
    end

    assign phase_divided_o = lane_phase;
    assign phase_valid_o   = vld_pipe[1];
    assign ftw_ack_o       = ack_pipe[1];
endmodule

// File: tb/tb_d3s_phase_gen.sv
// Scoreboard bench for d3s_phase_gen: stimulus queues expected words, a negedge
// monitor pops one per valid output word.

module tb_d3s_phase_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] ftw = '0;
    logic        ftw_load = 1'b0;
    logic        ftw_ack;
    logic        sync = 1'b0;
    logic [13:0] ofs = '0;
    logic [55:0] phase_divided;
    logic        phase_valid;

    int          checks = 0;
    int          errors = 0;
    int          nword = 0;
    logic [55:0] sb[$];
    logic [55:0] exp_w;

    always #5 clk = ~clk;

    d3s_phase_gen #(.g_acc_bits(32), .g_phase_bits(14)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .ftw_i          (ftw),
        .ftw_load_i     (ftw_load),
        .ftw_ack_o      (ftw_ack),
        .sync_i         (sync),
        .phase_ofs_i    (ofs),
        .phase_divided_o(phase_divided),
        .phase_valid_o  (phase_valid)
    );

    // Expected word from lane-0 phase, per-lane step and offset, all in 14-bit phase units.
    function automatic logic [55:0] w(input int base, input int s, input int o);
        logic [55:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k*14 +: 14] = 14'((base + k*s + o) & 16383);
        return r;
    endfunction

    task automatic check(input string name, input logic [55:0] got, input logic [55:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load_ftw(input logic [31:0] v);
        ftw      = v;
        ftw_load = 1'b1;
        cyc();
        ftw_load = 1'b0;
        check("ack_t0", ftw_ack, 0);
        cyc();
        check("ack_t1", ftw_ack, 1);
        cyc();
        check("ack_t2", ftw_ack, 0);
    endtask

    always @(negedge clk) begin
        if (phase_valid !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL word%0d unexpected got %h valid %b", nword, phase_divided, phase_valid);
            end else begin
                exp_w = sb.pop_front();
                if (phase_divided !== exp_w) begin
                    errors++;
                    $display("FAIL word%0d got %h want %h", nword, phase_divided, exp_w);
                end
            end
            nword++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid", phase_valid, 0);
        check("rst_data", phase_divided, 0);
        check("rst_ack", ftw_ack, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Enable, two words, then reset mid-run.
        load_ftw(32'h1000_0000);
        sb.push_back(w(0, 1024, 0));
        sb.push_back(w(4096, 1024, 0));
        enable = 1'b1;
        cyc();
        cyc();
        cyc();
        check("valid_e2", phase_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", phase_valid, 0);
        check("midrst_data", phase_divided, 0);
        check("midrst_ack", ftw_ack, 0);
        enable = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_rst_valid", phase_valid, 0);
        end

        // Long run: wrap, offset, sync, step change, sync+load, disable.
        load_ftw(32'h1000_0000);
        sb.push_back(w(0,     1024, 0));
        sb.push_back(w(4096,  1024, 0));
        sb.push_back(w(8192,  1024, 0));
        sb.push_back(w(12288, 1024, 100));
        sb.push_back(w(0,     1024, 100));
        sb.push_back(w(4096,  1024, 100));
        sb.push_back(w(8192,  1024, 100));
        sb.push_back(w(0,     1024, 100));
        sb.push_back(w(4096,  1024, 100));
        sb.push_back(w(8192,  1024, 100));
        sb.push_back(w(12288, 512,  100));
        sb.push_back(w(14336, 512,  100));
        sb.push_back(w(0,     512,  100));
        sb.push_back(w(2048,  512,  100));
        sb.push_back(w(0,     1024, 100));
        sb.push_back(w(4096,  1024, 100));
        enable = 1'b1;
        cyc();
        for (int n = 1; n <= 20; n++) begin
            enable   = (n <= 16);
            ftw_load = (n == 10 || n == 14);
            ftw      = (n == 10) ? 32'h0800_0000 : 32'h1000_0000;
            sync     = (n == 7 || n == 14);
            cyc();
            check($sformatf("ack_n%0d", n), ftw_ack, (n == 11 || n == 15) ? 1 : 0);
            if (n == 2 || n >= 19)
                check($sformatf("valid_n%0d", n), phase_valid, 0);
            if (n == 5)
                ofs = 14'd100;
        end

        // Sub-LSB step: truncation, not rounding.
        ofs = '0;
        load_ftw(32'h0003_FFFF);
        sb.push_back({14'd2, 14'd1, 14'd0, 14'd0});
        sb.push_back({14'd6, 14'd5, 14'd4, 14'd3});
        enable = 1'b1;
        cyc();
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        check("trunc_valid_low", phase_valid, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
